fetch_unit: RTL

Instruction fetch stage of the pipelined RV32I core: holds the PC, issues one-at-a-time requests to instruction memory over a valid/ready handshake, and loads the IF/ID pipeline register. The immediate generator and decoder read `if_id_inst`. The hazard unit controls the stage through `stall`; the execute stage controls it through `redirect_valid`/`redirect_pc`. At most one memory request is outstanding at any time.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit_if_id_reg.sv | 50 +++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default constants and a PC alignment helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2,
    FS_DROP = 2'd3
  } fetchState_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Instruction addresses are word aligned, so the low two bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel between the fetch stage
// (master) and instruction memory (slave).
interface fetch_unit_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and any cycle
// without a load inserts a bubble while keeping the last PC.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (hold_i) begin
      valid_q <= valid_q;
      pc_q    <= pc_q;
      inst_q  <= inst_q;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end else begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding-request FSM,
// stall hold buffer and the IF/ID pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  imem,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   pc,
  output logic          if_id_valid,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_inst
);

  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] holdBuf_q, holdBuf_d;
  logic        deliver;
  logic [31:0] deliverInst;
  logic        ifIdFlush;
  logic        ifIdHold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FS_REQ;
      pc_q      <= RESET_PC;
      holdBuf_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      holdBuf_q <= holdBuf_d;
    end
  end

  // Responses outside WAIT/DROP are protocol errors and fall through untouched.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    holdBuf_d   = holdBuf_q;
    deliver     = 1'b0;
    deliverInst = '0;

    unique case (state_q)
      FS_REQ: begin
        if (imem.imem_req_ready) begin
          state_d = redirect_valid ? FS_DROP : FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem.imem_resp_valid) begin
          if (redirect_valid) begin
            state_d = FS_REQ;
          end else if (!stall) begin
            deliver     = 1'b1;
            deliverInst = imem.imem_resp_data;
            pc_d        = pc_q + PC_STEP;
            state_d     = FS_REQ;
          end else begin
            holdBuf_d = imem.imem_resp_data;
            state_d   = FS_HOLD;
          end
        end else if (redirect_valid) begin
          state_d = FS_DROP;
        end
      end
      FS_HOLD: begin
        if (redirect_valid) begin
          holdBuf_d = '0;
          state_d   = FS_REQ;
        end else if (!stall) begin
          deliver     = 1'b1;
          deliverInst = holdBuf_q;
          holdBuf_d   = '0;
          pc_d        = pc_q + PC_STEP;
          state_d     = FS_REQ;
        end
      end
      FS_DROP: begin
        if (imem.imem_resp_valid) begin
          state_d = FS_REQ;
        end
      end
      default: begin
        state_d = FS_REQ;
      end
    endcase

    // A taken branch retargets the PC no matter which state we are in.
    if (redirect_valid) begin
      pc_d = alignPc(redirect_pc);
    end
  end

  assign ifIdFlush = redirect_valid;
  assign ifIdHold  = !redirect_valid && stall;

  assign imem.imem_req_valid = (state_q == FS_REQ);
  assign imem.imem_req_addr  = pc_q;
  assign pc                  = pc_q;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (deliver),
    .flush_i (ifIdFlush),
    .hold_i  (ifIdHold),
    .pc_i    (pc_q),
    .inst_i  (deliverInst),
    .valid_o (if_id_valid),
    .pc_o    (if_id_pc),
    .inst_o  (if_id_inst)
  );

endmodule
